// File: rtl/mac_unit_pragmatic_gen.sv
// -----------------------------------------------------------------------------
// mac_unit_pragmatic_gen
//
// Vector multiply-accumulate unit for shift-based (power-of-two) weights.
// Each beat carries VEC_LENGTH signed activations. Every lane is optionally
// negated, left-shifted by its own small shift, and gated by its enable. The
// lanes are summed in a full-width adder tree, and the lane sum is shifted by
// a shared second shift. The resulting beat term is accumulated over a dot
// product that is delimited by start/last.
//
// Pipeline: S1 registers the beat term with its tags, and S2 updates the
// accumulator. Once the final beat has left S2, the result (the accumulator
// top bits, or a max against result_prev for pooling) is registered and then
// held until the consumer accepts it.
//
// Ports
//   clk, reset         clock; synchronous active-high reset
//   in_valid/in_ready  beat handshake (in_ready low while draining/holding)
//   start, last        first / final beat of a dot product
//   load_prev          with start: seed accumulator from result_prev
//   is_pooling         with last: output max(acc top bits, result_prev)
//   act_in             packed signed activations, lane j at [j*DATA_WIDTH +:]
//   shift_1st_sel/_en  per-lane left shift and lane enable
//   is_neg             per-lane negate
//   shift_2nd_sel/_en  shared left shift of the lane sum; enable gates the beat
//   result_prev        signed seed / pooling operand
//   out_valid/out_ready result handshake
//   result             registered signed result
// -----------------------------------------------------------------------------
module mac_unit_pragmatic_gen #(
    parameter int DATA_WIDTH   = 8,
    parameter int VEC_LENGTH   = 16,
    parameter int SHIFT1_BITS  = 2,
    parameter int SHIFT2_BITS  = 3,
    parameter int ACC_WIDTH    = 24,
    parameter int RESULT_WIDTH = 16,
    parameter int SATURATE     = 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              start,
    input  logic                              last,
    input  logic                              load_prev,
    input  logic                              is_pooling,
    input  logic [VEC_LENGTH*DATA_WIDTH-1:0]  act_in,
    input  logic [VEC_LENGTH*SHIFT1_BITS-1:0] shift_1st_sel,
    input  logic [VEC_LENGTH-1:0]             shift_1st_en,
    input  logic [VEC_LENGTH-1:0]             is_neg,
    input  logic [SHIFT2_BITS-1:0]            shift_2nd_sel,
    input  logic                              shift_2nd_en,
    input  logic [RESULT_WIDTH-1:0]           result_prev,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [RESULT_WIDTH-1:0]           result
);

    // ---------------------------------------------------------------------
    // Derived widths
    // ---------------------------------------------------------------------
    localparam int MAX_SHIFT1 = (1 << SHIFT1_BITS) - 1;
    localparam int MAX_SHIFT2 = (1 << SHIFT2_BITS) - 1;
    localparam int LOG2V      = $clog2(VEC_LENGTH);
    // Lane: sign-extended activation (+1 bit for exact negation) plus shift.
    localparam int LANE_W     = DATA_WIDTH + 1 + MAX_SHIFT1;
    // Tree: every level adds one bit of growth.
    localparam int TREE_W     = LANE_W + LOG2V;
    // Beat term: tree result after the shared shift, untruncated.
    localparam int TERM_W     = TREE_W + MAX_SHIFT2;
    // S2 adder: one guard bit beyond the wider of accumulator and term.
    localparam int SUM_W      = ((TERM_W > ACC_WIDTH) ? TERM_W : ACC_WIDTH) + 1;
    localparam int SEED_SHIFT = ACC_WIDTH - RESULT_WIDTH;
    localparam int NODES      = 2 * VEC_LENGTH - 1;

    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    // ---------------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN,
        HOLD
    } state_t;

    state_t state_q, state_d;

    logic accept;

    // S1 stage
    logic                     s1_valid_q, s1_valid_d;
    logic signed [TERM_W-1:0] s1_term_q;
    logic                     s1_start_q;
    logic                     s1_last_q;
    logic                     s1_load_q;
    logic                     s1_pool_q;
    logic [RESULT_WIDTH-1:0]  s1_prev_q;

    // S2 stage
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                        s2_done_q;
    logic                        s2_pool_q;
    logic [RESULT_WIDTH-1:0]     s2_prev_q;

    // Output register
    logic [RESULT_WIDTH-1:0] result_q, result_d;

    assign accept = in_valid && in_ready;

    // ---------------------------------------------------------------------
    // Lane terms and adder tree
    //
    // The tree is stored heap-style: leaves occupy node[VEC_LENGTH-1 ..],
    // and node k sums its children 2k+1 and 2k+2, so node[0] is the full sum
    // after log2(VEC_LENGTH) levels. Every node uses the final tree width,
    // which means no partial sum can overflow.
    // ---------------------------------------------------------------------
    logic signed [TREE_W-1:0] node [NODES];
    logic signed [TERM_W-1:0] beat_term;

    always_comb begin : lane_tree_c
        logic signed [DATA_WIDTH:0] ext;
        logic signed [TREE_W-1:0]   wide;
        ext  = '0;
        wide = '0;
        for (int unsigned i = 0; i < NODES; i++) begin
            node[i] = '0;
        end
        for (int unsigned j = 0; j < VEC_LENGTH; j++) begin
            // Extend before negating so that the most negative code negates exactly.
            ext  = {act_in[j*DATA_WIDTH + DATA_WIDTH - 1], act_in[j*DATA_WIDTH +: DATA_WIDTH]};
            if (is_neg[j]) begin
                ext = -ext;
            end
            wide = TREE_W'(ext);
            if (shift_1st_en[j]) begin
                node[VEC_LENGTH - 1 + j] = wide <<< shift_1st_sel[j*SHIFT1_BITS +: SHIFT1_BITS];
            end
        end
        for (int unsigned i = 0; i < VEC_LENGTH - 1; i++) begin
            node[VEC_LENGTH - 2 - i] = node[2*(VEC_LENGTH - 2 - i) + 1]
                                     + node[2*(VEC_LENGTH - 2 - i) + 2];
        end
    end

    always_comb begin : beat_term_c
        beat_term = '0;
        if (shift_2nd_en) begin
            beat_term = TERM_W'(node[0]) <<< shift_2nd_sel;
        end
    end

    // Beats are discarded in IDLE unless they open a product.
    always_comb begin : s1_valid_c
        s1_valid_d = accept && (start || (state_q == ACCUM));
    end

    // ---------------------------------------------------------------------
    // S2 accumulate with saturation or wrap
    // ---------------------------------------------------------------------
    always_comb begin : s2_acc_c
        logic signed [ACC_WIDTH-1:0]     seed;
        logic signed [SUM_W-1:0]         base;
        logic signed [SUM_W-1:0]         sum;
        logic [SUM_W-ACC_WIDTH:0]        hi;
        logic                            ovf;
        seed = ACC_WIDTH'(signed'(s1_prev_q)) <<< SEED_SHIFT;
        if (s1_start_q) begin
            base = s1_load_q ? SUM_W'(seed) : '0;
        end else begin
            base = SUM_W'(acc_q);
        end
        sum = base + SUM_W'(s1_term_q);
        // In range only when every bit from the ACC sign bit upward agrees.
        hi  = sum[SUM_W-1:ACC_WIDTH-1];
        ovf = !((&hi) || !(|hi));

        acc_d = acc_q;
        if (s1_valid_q) begin
            if ((SATURATE != 0) && ovf) begin
                acc_d = sum[SUM_W-1] ? ACC_MIN : ACC_MAX;
            end else begin
                acc_d = sum[ACC_WIDTH-1:0];
            end
        end
    end

    // ---------------------------------------------------------------------
    // Result selection (taken once the final beat has updated acc_q)
    // ---------------------------------------------------------------------
    always_comb begin : result_c
        logic signed [RESULT_WIDTH-1:0] acc_top;
        acc_top  = acc_q[ACC_WIDTH-1 -: RESULT_WIDTH];
        result_d = result_q;
        if ((state_q == DRAIN) && s2_done_q) begin
            if (s2_pool_q && (signed'(s2_prev_q) > acc_top)) begin
                result_d = s2_prev_q;
            end else begin
                result_d = acc_top;
            end
        end
    end

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------------------
    always_comb begin : fsm_next_c
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept && start) begin
                    state_d = last ? DRAIN : ACCUM;
                end
            end
            ACCUM: begin
                if (accept && last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (s2_done_q) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------------
    always_comb begin : fsm_out_c
        in_ready  = (state_q == IDLE) || (state_q == ACCUM);
        out_valid = (state_q == HOLD);
    end

    // ---------------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_term_q  <= '0;
            s1_start_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_load_q  <= 1'b0;
            s1_pool_q  <= 1'b0;
            s1_prev_q  <= '0;
            acc_q      <= '0;
            s2_done_q  <= 1'b0;
            s2_pool_q  <= 1'b0;
            s2_prev_q  <= '0;
            result_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (accept) begin
                s1_term_q  <= beat_term;
                s1_start_q <= start;
                s1_last_q  <= last;
                s1_load_q  <= load_prev;
                s1_pool_q  <= is_pooling;
                s1_prev_q  <= result_prev;
            end
            acc_q     <= acc_d;
            s2_done_q <= s1_valid_q && s1_last_q;
            if (s1_valid_q && s1_last_q) begin
                s2_pool_q <= s1_pool_q;
                s2_prev_q <= s1_prev_q;
            end
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_mac_unit_pragmatic_gen.sv
// -----------------------------------------------------------------------------
// tb_mac_unit_pragmatic_gen
//
// Self-checking bench for mac_unit_pragmatic_gen with default parameters.
// It applies single-beat vectors from a table, hand-written multi-beat
// sequences (saturation, restart, pooling, backpressure, reset abort,
// discarded beats), and random products compared against an arithmetic
// reference model.
// -----------------------------------------------------------------------------
module tb_mac_unit_pragmatic_gen;

    localparam int DW  = 8;
    localparam int VL  = 16;
    localparam int S1B = 2;
    localparam int S2B = 3;
    localparam int AW  = 24;
    localparam int RW  = 16;
    localparam int SAT = 1;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic               start;
    logic               last;
    logic               load_prev;
    logic               is_pooling;
    logic [VL*DW-1:0]   act_in;
    logic [VL*S1B-1:0]  shift_1st_sel;
    logic [VL-1:0]      shift_1st_en;
    logic [VL-1:0]      is_neg;
    logic [S2B-1:0]     shift_2nd_sel;
    logic               shift_2nd_en;
    logic [RW-1:0]      result_prev;
    logic               out_valid;
    logic               out_ready;
    logic [RW-1:0]      result;

    mac_unit_pragmatic_gen #(
        .DATA_WIDTH  (DW),
        .VEC_LENGTH  (VL),
        .SHIFT1_BITS (S1B),
        .SHIFT2_BITS (S2B),
        .ACC_WIDTH   (AW),
        .RESULT_WIDTH(RW),
        .SATURATE    (SAT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .start        (start),
        .last         (last),
        .load_prev    (load_prev),
        .is_pooling   (is_pooling),
        .act_in       (act_in),
        .shift_1st_sel(shift_1st_sel),
        .shift_1st_en (shift_1st_en),
        .is_neg       (is_neg),
        .shift_2nd_sel(shift_2nd_sel),
        .shift_2nd_en (shift_2nd_en),
        .result_prev  (result_prev),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [VL*DW-1:0]  act;
        logic [VL*S1B-1:0] sel1;
        logic [VL-1:0]     en;
        logic [VL-1:0]     neg;
        logic [S2B-1:0]    sel2;
        logic              en2;
        logic              start;
        logic              last;
        logic              load;
        logic              pool;
        logic [RW-1:0]     prev;
    } beat_t;

    typedef struct {
        beat_t         b;
        logic [RW-1:0] exp;
        string         name;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Every lane carries the same activation and first shift.
    function automatic beat_t mk(input logic [7:0] a, input logic [15:0] en,
                                 input logic [15:0] neg, input logic [1:0] s1,
                                 input logic [2:0] s2, input logic en2);
        beat_t b;
        for (int j = 0; j < VL; j++) begin
            b.act[j*DW +: DW]   = a;
            b.sel1[j*S1B +: S1B] = s1;
        end
        b.en = en; b.neg = neg; b.sel2 = s2; b.en2 = en2;
        b.start = 1'b0; b.last = 1'b0; b.load = 1'b0; b.pool = 1'b0; b.prev = '0;
        return b;
    endfunction

    // ---------------- reference model (plain integer arithmetic) ----------
    function automatic longint term_of(input beat_t b);
        longint s = 0;
        longint a;
        for (int j = 0; j < VL; j++) begin
            a = longint'($signed(b.act[j*DW +: DW]));
            if (b.neg[j]) a = -a;
            if (b.en[j]) s += a * (longint'(1) << b.sel1[j*S1B +: S1B]);
        end
        if (!b.en2) return 0;
        return s * (longint'(1) << b.sel2);
    endfunction

    function automatic longint sat(input longint v);
        longint mx = (longint'(1) << (AW-1)) - 1;
        longint mn = -(longint'(1) << (AW-1));
        if (v > mx) return mx;
        if (v < mn) return mn;
        return v;
    endfunction

    function automatic logic [RW-1:0] model_product(input beat_t bs[8], input int n);
        longint acc = 0;
        longint top;
        longint pv;
        for (int i = 0; i < n; i++) begin
            if (bs[i].start)
                acc = bs[i].load ? longint'($signed(bs[i].prev)) * (longint'(1) << (AW-RW)) : 0;
            acc = sat(acc + term_of(bs[i]));
        end
        top = acc / (longint'(1) << (AW-RW));
        if ((acc < 0) && (top * (longint'(1) << (AW-RW)) != acc)) top = top - 1;
        pv = longint'($signed(bs[n-1].prev));
        if (bs[n-1].pool && (pv > top)) top = pv;
        return top[RW-1:0];
    endfunction

    // ---------------- drivers ----------------
    task automatic drive(input beat_t b);
        act_in = b.act; shift_1st_sel = b.sel1; shift_1st_en = b.en; is_neg = b.neg;
        shift_2nd_sel = b.sel2; shift_2nd_en = b.en2; start = b.start; last = b.last;
        load_prev = b.load; is_pooling = b.pool; result_prev = b.prev; in_valid = 1'b1;
    endtask

    task automatic quiet();
        in_valid = 1'b0; start = 1'b0; last = 1'b0; load_prev = 1'b0; is_pooling = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends n beats, checks the 2-cycle latency, result, hold stability, release.
    task automatic run_product(input beat_t bs[8], input int n, input logic [RW-1:0] exp,
                               input int bub, input int hold, input logic pre,
                               input string nm);
        int g;
        int cnt;
        out_ready = pre;
        for (int i = 0; i < n; i++) begin
            if (bub > 0) begin
                repeat ($urandom_range(0, bub)) begin quiet(); tick(); end
            end
            drive(bs[i]);
            g = 0;
            while (!in_ready && g < 20) begin tick(); g++; end
            tick();
        end
        quiet();
        cnt = 0;
        while (!out_valid && cnt < 10) begin tick(); cnt++; end
        chk({nm, " latency"}, 64'(cnt), 64'd2);
        chk({nm, " result"}, 64'(result), 64'(exp));
        if (!pre) begin
            for (int h = 0; h < hold; h++) begin
                tick();
                chk({nm, " hold valid"}, 64'(out_valid), 64'd1);
                chk({nm, " hold result"}, 64'(result), 64'(exp));
                chk({nm, " hold in_ready"}, 64'(in_ready), 64'd0);
            end
            out_ready = 1'b1;
        end
        tick();
        chk({nm, " release valid"}, 64'(out_valid), 64'd0);
        chk({nm, " release in_ready"}, 64'(in_ready), 64'd1);
        out_ready = 1'b0;
    endtask

    vec_t  tbl [11];
    beat_t seq [8];
    beat_t big, lane127, posmax, negmax, z;
    logic [RW-1:0] exp_r;
    int    n;

    initial begin
        reset = 1'b1; out_ready = 1'b0;
        act_in = '0; shift_1st_sel = '0; shift_1st_en = '0; is_neg = '0;
        shift_2nd_sel = '0; shift_2nd_en = 1'b0; result_prev = '0;
        quiet();
        tick(); tick();
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset in_ready", 64'(in_ready), 64'd1);
        chk("reset result", 64'(result), 64'd0);
        reset = 1'b0;
        tick();

        // -------- single-beat table --------
        lane127 = mk(8'd127, 16'h0001, 16'h0000, 2'd3, 3'd7, 1'b1);
        posmax  = mk(8'h80, 16'hFFFF, 16'hFFFF, 2'd3, 3'd7, 1'b1);
        negmax  = mk(8'h80, 16'hFFFF, 16'h0000, 2'd3, 3'd7, 1'b1);
        big     = mk(8'd127, 16'hFFFF, 16'h0000, 2'd3, 3'd7, 1'b1);
        z       = mk(8'd55, 16'hFFFF, 16'h0000, 2'd0, 3'd0, 1'b0);

        tbl[0].b = mk(8'd1, 16'hFFFF, 16'h0000, 2'd0, 3'd0, 1'b1); tbl[0].exp = 16'h0000; tbl[0].name = "ones";
        tbl[1].b = mk(8'h80, 16'h0001, 16'h0001, 2'd3, 3'd7, 1'b1); tbl[1].exp = 16'h0200; tbl[1].name = "neg128";
        tbl[2].b = big;                                             tbl[2].exp = 16'h1FC0; tbl[2].name = "all127";
        tbl[3].b = negmax;                                          tbl[3].exp = 16'hE000; tbl[3].name = "all-128";
        tbl[4].b = z; tbl[4].b.load = 1'b1; tbl[4].b.prev = 16'h0010; tbl[4].exp = 16'h0010; tbl[4].name = "load_prev";
        tbl[5].b = negmax; tbl[5].b.load = 1'b1; tbl[5].b.prev = 16'h8000; tbl[5].exp = 16'h8000; tbl[5].name = "sat_min";
        tbl[6].b = posmax; tbl[6].b.load = 1'b1; tbl[6].b.prev = 16'h7FFF; tbl[6].exp = 16'h7FFF; tbl[6].name = "sat_max";
        tbl[7].b = mk(8'd127, 16'h0001, 16'h0000, 2'd3, 3'd7, 1'b1); tbl[7].exp = 16'h01FC; tbl[7].name = "lane_en";
        tbl[8].b = lane127; tbl[8].b.pool = 1'b1; tbl[8].b.prev = 16'd1000; tbl[8].exp = 16'd1000; tbl[8].name = "pool_prev";
        tbl[9].b = mk(8'hFF, 16'h0001, 16'h0000, 2'd0, 3'd0, 1'b1); tbl[9].b.load = 1'b1; tbl[9].b.prev = 16'h0001;
        tbl[9].exp = 16'h0000; tbl[9].name = "borrow";
        tbl[10].b = mk(8'd64, 16'hFFFF, 16'h000F, 2'd0, 3'd7, 1'b1); tbl[10].exp = 16'h0100; tbl[10].name = "partial_neg";

        for (int i = 0; i < 11; i++) begin
            seq[0] = tbl[i].b; seq[0].start = 1'b1; seq[0].last = 1'b1;
            run_product(seq, 1, tbl[i].exp, 0, 1, 1'b0, tbl[i].name);
        end

        // -------- three beats of lane 127, with bubbles --------
        for (int i = 0; i < 3; i++) seq[i] = lane127;
        seq[0].start = 1'b1; seq[2].last = 1'b1;
        run_product(seq, 3, 16'h05F4, 2, 1, 1'b0, "three127");

        // -------- saturation across beats --------
        for (int i = 0; i < 4; i++) seq[i] = posmax;
        seq[0].start = 1'b1; seq[3].last = 1'b1;
        run_product(seq, 4, 16'h7FFF, 0, 0, 1'b0, "sat_pos");
        for (int i = 0; i < 5; i++) seq[i] = negmax;
        seq[0].start = 1'b1; seq[4].last = 1'b1;
        run_product(seq, 5, 16'h8000, 0, 0, 1'b0, "sat_neg");

        // -------- start in ACCUM restarts the product --------
        seq[0] = big; seq[0].start = 1'b1; seq[1] = big;
        seq[2] = lane127; seq[2].start = 1'b1; seq[3] = lane127; seq[3].last = 1'b1;
        run_product(seq, 4, 16'h03F8, 0, 0, 1'b0, "restart");

        // -------- pooling: top=-5 against result_prev=3 --------
        seq[0] = z; seq[0].start = 1'b1; seq[0].load = 1'b1; seq[0].prev = 16'hFFFB;
        seq[1] = z; seq[1].last = 1'b1; seq[1].pool = 1'b1; seq[1].prev = 16'h0003;
        run_product(seq, 2, 16'h0003, 0, 0, 1'b0, "pool_max");
        seq[1].pool = 1'b0;
        run_product(seq, 2, 16'hFFFB, 0, 0, 1'b0, "pool_off");

        // -------- backpressure: 5 held cycles; out_ready early is ignored --------
        seq[0] = big; seq[0].start = 1'b1; seq[0].last = 1'b1;
        run_product(seq, 1, 16'h1FC0, 0, 5, 1'b0, "backpressure");
        run_product(seq, 1, 16'h1FC0, 0, 0, 1'b1, "early_ready");

        // -------- beats without start in IDLE are discarded --------
        seq[0] = big; seq[0].last = 1'b1;
        drive(seq[0]); tick(); quiet();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("discard out_valid", 64'(out_valid), 64'd0);
        end
        chk("discard in_ready", 64'(in_ready), 64'd1);

        // -------- reset in ACCUM after 2 beats --------
        seq[0] = big; seq[0].start = 1'b1;
        drive(seq[0]); tick();
        drive(big); tick();
        quiet(); reset = 1'b1; tick(); reset = 1'b0;
        chk("abort in_ready", 64'(in_ready), 64'd1);
        chk("abort result", 64'(result), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("abort out_valid", 64'(out_valid), 64'd0);
        end
        seq[0] = lane127; seq[0].start = 1'b1; seq[0].last = 1'b1;
        run_product(seq, 1, 16'h01FC, 0, 0, 1'b0, "after_abort");

        // -------- random products vs reference model --------
        for (int r = 0; r < 40; r++) begin
            n = $urandom_range(1, 5);
            for (int i = 0; i < n; i++) begin
                for (int j = 0; j < VL; j++) seq[i].act[j*DW +: DW] = DW'($urandom);
                seq[i].sel1 = ($urandom << 16) ^ $urandom;
                seq[i].en   = 16'($urandom);
                seq[i].neg  = 16'($urandom);
                seq[i].sel2 = 3'($urandom);
                seq[i].en2  = ($urandom_range(0, 7) != 0);
                seq[i].start = (i == 0);
                seq[i].last  = (i == n - 1);
                seq[i].load  = (i == 0) && $urandom_range(0, 1) == 1;
                seq[i].pool  = (i == n - 1) && $urandom_range(0, 2) == 0;
                seq[i].prev  = 16'($urandom);
            end
            exp_r = model_product(seq, n);
            run_product(seq, n, exp_r, 2, $urandom_range(0, 3),
                        1'($urandom_range(0, 1)), "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
